// File: rtl/soc_mem_pkg.sv
// Shared size encodings, FSM state type and default read latency for soc_mem_ctrl.
package soc_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam int unsigned RD_LATENCY_DEF = 1;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

endpackage

// File: rtl/soc_mem_lane_fmt.sv
// Combinational byte-lane steering for stores and lane extract / extension for loads.
module soc_mem_lane_fmt
   import soc_mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_wea,
   output logic [31:0] o_dia,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
   assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

   always_comb begin
      o_wea   = 4'b0000;
      o_dia   = '0;
      o_rdata = '0;
      unique case (i_size)
         SZ_BYTE: begin
            o_wea   = 4'b0001 << i_off;
            o_dia   = {4{i_wdata[7:0]}};
            o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            o_wea   = i_off[1] ? 4'b1100 : 4'b0011;
            o_dia   = {2{i_wdata[15:0]}};
            o_rdata = {{16{i_signed & w_half[15]}}, w_half};
         end
         default: begin
            o_wea   = 4'b1111;
            o_dia   = i_wdata;
            o_rdata = i_rdata;
         end
      endcase
   end

endmodule

// File: rtl/soc_mem_ctrl.sv
// Load/store adapter in front of a synchronous block RAM, one request at a time.
// Define SOC_MEM_CTRL_ALIGN_CHK_EN to reject misaligned/reserved requests with rsp_err.
module soc_mem_ctrl
   import soc_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
   input  logic              clka,
   input  logic              rsta_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [31:0]       mem_dia,
   output logic [3:0]        mem_wea,
   input  logic [31:0]       mem_doa,
   output logic              mem_rsta
);

   state_e            r_state, w_state_d;
   logic              r_req_ready, w_req_ready_d;
   logic              r_rsp_valid, w_rsp_valid_d;
   logic              r_rsp_err, w_rsp_err_d;
   logic [31:0]       r_rsp_rdata, w_rsp_rdata_d;
   logic [ADDR_W-1:0] r_mem_addra, w_mem_addra_d;
   logic [31:0]       r_mem_dia, w_mem_dia_d;
   logic [3:0]        r_mem_wea, w_mem_wea_d;
   logic [1:0]        r_size, w_size_d;
   logic [1:0]        r_off, w_off_d;
   logic              r_signed, w_signed_d;
   logic              r_we, w_we_d;
   logic              r_wait_cnt, w_wait_cnt_d;

   logic [1:0]        w_size_n;
   logic [1:0]        w_off_n;
   logic              w_err;
   logic [1:0]        w_fmt_size;
   logic [1:0]        w_fmt_off;
   logic              w_fmt_signed;
   logic [3:0]        w_fmt_wea;
   logic [31:0]       w_fmt_dia;
   logic [31:0]       w_fmt_rdata;

   // Normalise the incoming request: reserved size and sub-size offset bits.
   always_comb begin
      w_size_n = req_size;
      w_off_n  = req_addr[1:0];
      w_err    = 1'b0;
`ifdef SOC_MEM_CTRL_ALIGN_CHK_EN
      w_err = (req_size == SZ_RSVD) ||
              ((req_size == SZ_HALF) && req_addr[0]) ||
              ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
      if (req_size == SZ_RSVD) begin
         w_size_n = SZ_WORD;
      end
`endif
      if (w_size_n == SZ_HALF) begin
         w_off_n[0] = 1'b0;
      end else if (w_size_n == SZ_WORD) begin
         w_off_n = 2'b00;
      end
   end

   // One formatter serves both paths: live request in IDLE, latched request otherwise.
   assign w_fmt_size   = (r_state == StIdle) ? w_size_n   : r_size;
   assign w_fmt_off    = (r_state == StIdle) ? w_off_n    : r_off;
   assign w_fmt_signed = (r_state == StIdle) ? req_signed : r_signed;

   soc_mem_lane_fmt u_lane_fmt (
      .i_size   (w_fmt_size),
      .i_off    (w_fmt_off),
      .i_signed (w_fmt_signed),
      .i_wdata  (req_wdata),
      .i_rdata  (mem_doa),
      .o_wea    (w_fmt_wea),
      .o_dia    (w_fmt_dia),
      .o_rdata  (w_fmt_rdata)
   );

   always_comb begin
      w_state_d     = r_state;
      w_rsp_valid_d = r_rsp_valid;
      w_rsp_err_d   = r_rsp_err;
      w_rsp_rdata_d = r_rsp_rdata;
      w_mem_addra_d = r_mem_addra;
      w_mem_dia_d   = r_mem_dia;
      w_mem_wea_d   = 4'b0000;
      w_size_d      = r_size;
      w_off_d       = r_off;
      w_signed_d    = r_signed;
      w_we_d        = r_we;
      w_wait_cnt_d  = r_wait_cnt;

      unique case (r_state)
         StIdle: begin
            if (req_valid && r_req_ready) begin
               w_size_d      = w_size_n;
               w_off_d       = w_off_n;
               w_signed_d    = req_signed;
               w_we_d        = req_we;
               w_rsp_rdata_d = '0;
               if (w_err) begin
                  w_state_d     = StResp;
                  w_rsp_valid_d = 1'b1;
                  w_rsp_err_d   = 1'b1;
               end else begin
                  w_state_d     = StIssue;
                  w_mem_addra_d = req_addr[ADDR_W+1:2];
                  w_mem_dia_d   = w_fmt_dia;
                  w_mem_wea_d   = req_we ? w_fmt_wea : 4'b0000;
               end
            end
         end
         StIssue: begin
            if (r_we) begin
               w_state_d     = StResp;
               w_rsp_valid_d = 1'b1;
            end else begin
               w_state_d    = StWait;
               w_wait_cnt_d = 1'(RD_LATENCY - 1);
            end
         end
         StWait: begin
            if (r_wait_cnt == 1'b0) begin
               w_rsp_rdata_d = w_fmt_rdata;
               w_rsp_valid_d = 1'b1;
               w_state_d     = StResp;
            end else begin
               w_wait_cnt_d = r_wait_cnt - 1'b1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               w_state_d     = StIdle;
               w_rsp_valid_d = 1'b0;
               w_rsp_err_d   = 1'b0;
            end
         end
         default: w_state_d = StIdle;
      endcase

      w_req_ready_d = (w_state_d == StIdle);
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         r_state     <= StIdle;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_mem_addra <= '0;
         r_mem_dia   <= '0;
         r_mem_wea   <= 4'b0000;
         r_size      <= SZ_BYTE;
         r_off       <= 2'b00;
         r_signed    <= 1'b0;
         r_we        <= 1'b0;
         r_wait_cnt  <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_req_ready <= w_req_ready_d;
         r_rsp_valid <= w_rsp_valid_d;
         r_rsp_err   <= w_rsp_err_d;
         r_rsp_rdata <= w_rsp_rdata_d;
         r_mem_addra <= w_mem_addra_d;
         r_mem_dia   <= w_mem_dia_d;
         r_mem_wea   <= w_mem_wea_d;
         r_size      <= w_size_d;
         r_off       <= w_off_d;
         r_signed    <= w_signed_d;
         r_we        <= w_we_d;
         r_wait_cnt  <= w_wait_cnt_d;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign mem_addra = r_mem_addra;
   assign mem_dia   = r_mem_dia;
   assign mem_wea   = r_mem_wea;
   assign mem_rsta  = ~rsta_n;

endmodule

// File: tb/tb_soc_mem_ctrl.sv
// Randomised bench for soc_mem_ctrl against a byte-array reference memory.
module tb_soc_mem_ctrl;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned RD_LAT = 1;

   logic              clka = 1'b0;
   logic              rsta_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [1:0]        req_size = 2'b00;
   logic              req_signed = 1'b0;
   logic [ADDR_W+1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_addra;
   logic [31:0]       mem_dia;
   logic [3:0]        mem_wea;
   logic [31:0]       mem_doa = '0;
   logic              mem_rsta;

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] ram [0:(1<<ADDR_W)-1];
   logic [7:0]  ref_mem [0:(1<<(ADDR_W+2))-1];

   always #5 clka = ~clka;

   soc_mem_ctrl #(
      .ADDR_W     (ADDR_W),
      .RD_LATENCY (RD_LAT)
   ) dut (
      .clka       (clka),
      .rsta_n     (rsta_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addra  (mem_addra),
      .mem_dia    (mem_dia),
      .mem_wea    (mem_wea),
      .mem_doa    (mem_doa),
      .mem_rsta   (mem_rsta)
   );

   // Block RAM stand-in, one cycle read latency.
   always @(posedge clka) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_wea[i]) ram[mem_addra][8*i +: 8] <= mem_dia[8*i +: 8];
      end
      mem_doa <= ram[mem_addra];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request, compare everything the reference expects, then consume the response.
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [13:0] addr, input logic [31:0] wdata, input int stall,
                         output logic [31:0] got);
      int          nb;
      int          lat;
      int          w;
      logic [1:0]  esz;
      logic [13:0] ea;
      logic        err;
      logic [3:0]  ewea;
      logic [31:0] edia;
      logic [31:0] erd;
      logic [3:0]  wea1;
      logic [11:0] addr1;
      logic [31:0] dia1;
      logic        extra;
      logic        stab_bad;
      logic [31:0] snap;

      err = 1'b0;
      esz = size;
`ifdef SOC_MEM_CTRL_ALIGN_CHK_EN
      err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`else
      if (size == 2'd3) esz = 2'd2;
`endif
      nb   = 1 << esz;
      ea   = addr & ~14'(nb - 1);
      ewea = 4'(((1 << nb) - 1) << ea[1:0]);
      for (int i = 0; i < 4; i++) edia[8*i +: 8] = wdata[8*(i % nb) +: 8];
      erd = '0;
      if (!we && !err) begin
         for (int k = 0; k < nb; k++) erd[8*k +: 8] = ref_mem[int'(ea) + k];
         if (sgn && nb < 4 && erd[8*nb-1]) erd = erd | ~((32'h1 << (8*nb)) - 32'h1);
      end

      @(negedge clka);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      rsp_ready  = 1'b0;
      for (w = 0; w < 20 && !req_ready; w++) @(negedge clka);
      if (!req_ready) begin
         check("req_ready_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         got = '0;
         return;
      end
      @(negedge clka);
      req_valid = 1'b0;
      wea1  = mem_wea;
      addr1 = mem_addra;
      dia1  = mem_dia;
      extra = 1'b0;
      lat   = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clka);
         lat++;
         if (mem_wea != 4'b0000) extra = 1'b1;
      end

      check("latency", 32'(lat), err ? 32'd1 : (we ? 32'd2 : 32'(2 + RD_LAT)));
      check("wea_issue", 32'(wea1), (we && !err) ? 32'(ewea) : 32'd0);
      if (!err) check("addra", 32'(addr1), 32'(ea[13:2]));
      if (we && !err) check("dia", dia1, edia);
      check("wea_after", 32'(extra), 32'd0);
      check("rdata", rsp_rdata, (we || err) ? 32'd0 : erd);
      check("err", 32'(rsp_err), 32'(err));
      got = rsp_rdata;

      if (stall > 0) begin
         snap     = rsp_rdata;
         stab_bad = 1'b0;
         for (int s = 0; s < stall; s++) begin
            @(negedge clka);
            if (rsp_valid !== 1'b1 || rsp_rdata !== snap || req_ready !== 1'b0 ||
                mem_wea !== 4'b0000) stab_bad = 1'b1;
         end
         check("stall_stable", 32'(stab_bad), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clka);
      rsp_ready = 1'b0;
      check("ready_after", 32'(req_ready), 32'd1);
      check("valid_after", 32'(rsp_valid), 32'd0);

      if (we && !err) begin
         for (int k = 0; k < nb; k++) ref_mem[int'(ea) + k] = wdata[8*k +: 8];
      end
   endtask

   initial begin
      logic [31:0] got;
      logic [1:0]  rsz;

      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
      for (int i = 0; i < (1 << (ADDR_W + 2)); i++) ref_mem[i] = '0;

      // Reset behaviour
      repeat (2) @(negedge clka);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsta", 32'(mem_rsta), 32'd1);
      check("rst_wea", 32'(mem_wea), 32'd0);
      check("rst_addra", 32'(mem_addra), 32'd0);
      check("rst_dia", mem_dia, 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      rsta_n = 1'b1;
      #1;
      check("rel_ready_pre", 32'(req_ready), 32'd0);
      check("rel_rsta", 32'(mem_rsta), 32'd0);
      @(negedge clka);
      check("rel_ready_post", 32'(req_ready), 32'd1);

      // Directed scenarios
      do_req(1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF, 0, got);
      do_req(1'b0, 2'd2, 1'b0, 14'h010, 32'h0, 0, got);
      check("ld_word", got, 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 14'h012, 32'h0, 0, got);
`ifndef SOC_MEM_CTRL_ALIGN_CHK_EN
      check("ld_word_misal", got, 32'hDEADBEEF);
`endif
      do_req(1'b1, 2'd0, 1'b0, 14'h013, 32'h00000080, 0, got);
      do_req(1'b0, 2'd0, 1'b1, 14'h013, 32'h0, 0, got);
      check("ld_byte_s", got, 32'hFFFFFF80);
      do_req(1'b0, 2'd0, 1'b0, 14'h013, 32'h0, 0, got);
      check("ld_byte_u", got, 32'h00000080);
      do_req(1'b1, 2'd1, 1'b0, 14'h016, 32'h00008001, 0, got);
      do_req(1'b0, 2'd1, 1'b1, 14'h016, 32'h0, 5, got);
      check("ld_half_s", got, 32'hFFFF8001);

      // Reset during a store's ISSUE cycle must block the write.
      do_req(1'b1, 2'd2, 1'b0, 14'h020, 32'h11223344, 0, got);
      @(negedge clka);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 14'h020;
      req_wdata = 32'hAAAAAAAA;
      for (int w = 0; w < 20 && !req_ready; w++) @(negedge clka);
      @(negedge clka);
      req_valid = 1'b0;
      check("abort_wea_issue", 32'(mem_wea), 32'hF);
      rsta_n = 1'b0;
      #1;
      check("abort_wea_clr", 32'(mem_wea), 32'd0);
      check("abort_rsta", 32'(mem_rsta), 32'd1);
      @(negedge clka);
      check("abort_valid", 32'(rsp_valid), 32'd0);
      rsta_n = 1'b1;
      @(negedge clka);
      do_req(1'b0, 2'd2, 1'b0, 14'h020, 32'h0, 0, got);
      check("abort_word", got, 32'h11223344);

      // Randomised traffic over a small window so loads hit earlier stores.
      for (int t = 0; t < 80; t++) begin
         rsz = 2'($urandom_range(0, 3));
         do_req(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
                14'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)), got);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
